tick_bcd_stopwatch: RTL and testbench
=====================================

# tick_bcd_stopwatch

Downstream consumer of the periodic timer tick: counts tick pulses as a 4-digit BCD MM:SS value under start/stop/clear control, for direct feed to the display decoder. Sits between the tick timer (tick source, typically 1 Hz) and the 7-segment driver. It owns the run/pause state machine and the rollover logic; the tick period is set entirely upstream.

## Interface
Parameters:
- MIN_MAX, default 59: highest minutes value, legal range 1..99; MIN_MAX:59 rolls over to 00:00.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tick  input  1  count enable from the tick timer; every cycle with tick=1 counts as one second.
- start  input  1  synchronous start/resume request, sampled every cycle.
- stop  input  1  synchronous pause request.
- clear  input  1  synchronous clear to 00:00 and return to IDLE.
- bcd  output  16  {min_hi, min_lo, sec_hi, sec_lo}, 4 bits per digit, registered.
- running  output  1  1 while in RUN, registered.
- wrap  output  1  one-cycle pulse on MIN_MAX:59 -> 00:00 rollover.

## Operation
- States: IDLE (count 00:00, not counting), RUN (counting), PAUSE (count held, not counting).
- Transitions, evaluated each cycle with priority clear > stop > start:
  - any state, clear=1 -> IDLE, bcd <= 0000.
  - RUN, stop=1 -> PAUSE.
  - IDLE or PAUSE, start=1 -> RUN.
  - start in RUN, stop in IDLE/PAUSE: ignored.
- Increment happens only when the current state is RUN, tick=1 and clear=0:
  - sec_lo 0..9; at 9 -> 0, carry to sec_hi.
  - sec_hi 0..5; at 5 with carry -> 0, carry to minutes.
  - minutes form decimal 00..MIN_MAX from min_hi:min_lo; at MIN_MAX with carry -> 00, wrap=1 for that cycle.
- Every digit always holds a valid BCD value (0..9; sec_hi 0..5); no digit ever holds A..F.
- Rollover does not change state: remains RUN after wrap.
- Inputs start/stop/clear are levels; holding one high repeats its effect each cycle. No debouncing or edge detection inside this block.

## Timing
- Reset (reset=0, asynchronous): state IDLE, bcd=16'h0000, running=0, wrap=0; lap outputs (if built) zero.
- Latency: tick sampled at edge N -> new bcd visible after edge N, i.e. one cycle.
- running updates in the cycle after the start/stop/clear that causes the transition.
- tick and stop in the same RUN cycle: tick is counted, state becomes PAUSE.
- tick and start in the same IDLE/PAUSE cycle: tick is not counted (state was not RUN).
- tick and clear in the same cycle: no increment, bcd=0000.
- wrap: high exactly one cycle, aligned with bcd=0000 after rollover.
- reset asserted mid-count: immediate asynchronous return to reset values; deassertion is synchronous to clk by upstream convention.

## Configuration
- SW_LAP_EN defined: adds ports lap (input, 1) and lap_bcd (output, 16) plus lap_valid (output, 1).
  - In RUN or PAUSE, lap=1 captures the current (pre-increment) bcd into lap_bcd and sets lap_valid=1.
  - Counting continues unaffected; clear or reset zeroes lap_bcd and lap_valid.
  - lap in IDLE is ignored.
- SW_LAP_EN undefined: lap ports and lap register absent; behaviour otherwise identical.

## Test plan
- Reset, then start pulse, 10 ticks -> bcd=16'h0010, running=1.
- Start, 59 ticks -> 0059; one more tick -> 0100; stop pulse, 5 further ticks -> bcd stays 0100, running=0.
- Preload by 59*60+59 ticks with MIN_MAX=59 -> 5959; next tick -> 0000, wrap=1 for exactly one cycle, running stays 1.
- Simultaneous tick+stop at 0007 -> 0008 and PAUSE; simultaneous tick+clear at 0012 -> 0000, IDLE.
- Assert reset mid-run at 0345 -> bcd=0000, running=0, wrap=0 immediately, without waiting for a clk edge.
- SW_LAP_EN: at 0030 pulse lap -> lap_bcd=0030, lap_valid=1; 5 more ticks -> bcd=0035, lap_bcd still 0030; clear -> both zero, lap_valid=0.

Source files
------------

// File: rtl/tick_bcd_stopwatch.sv
// Purpose : counts timer ticks as a 4-digit BCD MM:SS stopwatch with run/pause/clear control.
// Latency : one cycle from a sampled tick/start/stop/clear to the registered bcd/running/wrap.
// Backpr. : none; every tick seen while running is counted, and inputs are levels acted on every cycle.
//
// Optional feature: define SW_LAP_EN to build the lap capture register (ports lap, lap_bcd, lap_valid).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   tick       count enable, one second per cycle high (while running)
//   start      start/resume request (IDLE or PAUSE -> RUN)
//   stop       pause request (RUN -> PAUSE)
//   clear      clear to 00:00 and return to IDLE (highest priority)
//   lap        [SW_LAP_EN] capture the current time into lap_bcd
//   lap_bcd    [SW_LAP_EN] captured time, same digit layout as bcd
//   lap_valid  [SW_LAP_EN] lap_bcd holds a capture since the last clear/reset
//   bcd        {min_hi, min_lo, sec_hi, sec_lo}
//   running    high while in RUN
//   wrap       one-cycle pulse coincident with the MIN_MAX:59 -> 00:00 rollover
module tick_bcd_stopwatch #(
  parameter int MIN_MAX = 59
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
`ifdef SW_LAP_EN
  input  logic        lap,
  output logic [15:0] lap_bcd,
  output logic        lap_valid,
`endif
  output logic [15:0] bcd,
  output logic        running,
  output logic        wrap
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Minutes limit split into its two decimal digits so the rollover test
  // is a plain digit compare rather than a BCD-to-binary conversion.
  localparam logic [3:0] MAX_TENS = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_ONES = 4'(MIN_MAX % 10);

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic [3:0] sec_lo;
  logic [3:0] sec_hi;
  logic [3:0] min_lo;
  logic [3:0] min_hi;

  logic [3:0] sec_lo_nxt;
  logic [3:0] sec_hi_nxt;
  logic [3:0] min_lo_nxt;
  logic [3:0] min_hi_nxt;

  logic       inc;
  logic       sec_lo_carry;
  logic       sec_hi_carry;
  logic       min_at_max;
  logic       roll;

  // ---------------------------------------------------------------------------
  // Run/pause state machine. clear beats stop beats start; a request that has
  // no meaning in the current state (start in RUN, stop in IDLE/PAUSE) is a
  // no-op rather than blocking a lower-priority request.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (stop) state_nxt = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (start) state_nxt = ST_RUN;
        end
        default: begin
          // Unreachable encoding: recover to a known state.
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // BCD counter. The increment is qualified by the *current* state, so a tick
  // arriving with stop is still counted, while a tick arriving with start is
  // not (the block was not yet running on that edge).
  // ---------------------------------------------------------------------------
  assign inc          = (state == ST_RUN) && tick && !clear;
  assign sec_lo_carry = (sec_lo == 4'd9);
  assign sec_hi_carry = sec_lo_carry && (sec_hi == 4'd5);
  assign min_at_max   = (min_hi == MAX_TENS) && (min_lo == MAX_ONES);
  assign roll         = inc && sec_hi_carry && min_at_max;

  always_comb begin
    sec_lo_nxt = sec_lo;
    sec_hi_nxt = sec_hi;
    min_lo_nxt = min_lo;
    min_hi_nxt = min_hi;
    if (inc) begin
      if (!sec_lo_carry) begin
        sec_lo_nxt = sec_lo + 4'd1;
      end else begin
        sec_lo_nxt = 4'd0;
        if (!sec_hi_carry) begin
          sec_hi_nxt = sec_hi + 4'd1;
        end else begin
          sec_hi_nxt = 4'd0;
          if (min_at_max) begin
            min_lo_nxt = 4'd0;
            min_hi_nxt = 4'd0;
          end else if (min_lo == 4'd9) begin
            min_lo_nxt = 4'd0;
            min_hi_nxt = min_hi + 4'd1;
          end else begin
            min_lo_nxt = min_lo + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_lo <= 4'd0;
      sec_hi <= 4'd0;
      min_lo <= 4'd0;
      min_hi <= 4'd0;
      wrap   <= 1'b0;
    end else if (clear) begin
      sec_lo <= 4'd0;
      sec_hi <= 4'd0;
      min_lo <= 4'd0;
      min_hi <= 4'd0;
      wrap   <= 1'b0;
    end else begin
      sec_lo <= sec_lo_nxt;
      sec_hi <= sec_hi_nxt;
      min_lo <= min_lo_nxt;
      min_hi <= min_hi_nxt;
      // Registered alongside the digits so the pulse lines up with 00:00.
      wrap   <= roll;
    end
  end

  assign bcd = {min_hi, min_lo, sec_hi, sec_lo};

`ifdef SW_LAP_EN
  // ---------------------------------------------------------------------------
  // Lap capture: snapshots the value on display before this cycle's increment.
  // Ignored in IDLE, where the count is always 00:00 anyway.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_bcd   <= 16'h0000;
      lap_valid <= 1'b0;
    end else if (clear) begin
      lap_bcd   <= 16'h0000;
      lap_valid <= 1'b0;
    end else if (lap && (state != ST_IDLE)) begin
      lap_bcd   <= bcd;
      lap_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tick_bcd_stopwatch.sv
module tb_tick_bcd_stopwatch;

  localparam int MIN_MAX = 59;
  localparam int LIMIT   = (MIN_MAX + 1) * 60;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        start;
  logic        stop;
  logic        clear;
  logic [15:0] bcd;
  logic        running;
  logic        wrap;
`ifdef SW_LAP_EN
  logic        lap;
  logic [15:0] lap_bcd;
  logic        lap_valid;
`endif

  int n_checks;
  int n_fail;

  // Reference model: elapsed seconds as a plain integer, state as a small int.
  int m_secs;
  int m_state;
  bit m_wrap;
  int m_lap_secs;
  bit m_lap_vld;

  tick_bcd_stopwatch #(.MIN_MAX(MIN_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
`ifdef SW_LAP_EN
    .lap       (lap),
    .lap_bcd   (lap_bcd),
    .lap_valid (lap_valid),
`endif
    .bcd       (bcd),
    .running   (running),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  function automatic void model_reset();
    m_secs     = 0;
    m_state    = S_IDLE;
    m_wrap     = 1'b0;
    m_lap_secs = 0;
    m_lap_vld  = 1'b0;
  endfunction

  function automatic void model_step(input bit st, input bit sp, input bit cl,
                                     input bit tk, input bit lp);
    int old;
    old    = m_secs;
    m_wrap = 1'b0;
    if (cl) begin
      m_secs     = 0;
      m_state    = S_IDLE;
      m_lap_secs = 0;
      m_lap_vld  = 1'b0;
    end else begin
      if (m_state == S_RUN && tk) begin
        m_secs = (m_secs + 1) % LIMIT;
        if (m_secs == 0) m_wrap = 1'b1;
      end
      if (lp && m_state != S_IDLE) begin
        m_lap_secs = old;
        m_lap_vld  = 1'b1;
      end
      if (sp && m_state == S_RUN) m_state = S_PAUSE;
      else if (st && m_state != S_RUN) m_state = S_RUN;
    end
  endfunction

  // Drive one cycle of inputs (just after a rising edge), advance the model at
  // the next rising edge, and return 1 time unit later for sampling.
  task automatic cycle(input bit st, input bit sp, input bit cl, input bit tk, input bit lp);
    start = st;
    stop  = sp;
    clear = cl;
    tick  = tk;
`ifdef SW_LAP_EN
    lap   = lp;
`endif
    @(posedge clk);
    model_step(st, sp, cl, tk, lp);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got=%b exp=0", running); end
    n_checks++;
    if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
`ifdef SW_LAP_EN
    n_checks++;
    if (lap_bcd !== 16'h0000 || lap_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_lap got=%h/%b exp=0000/0", lap_bcd, lap_valid);
    end
`endif
    // start and tick held during reset must have no effect
    start = 1'b1;
    tick  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bcd !== 16'h0000 || running !== 1'b0) begin
      n_fail++; $display("FAIL reset_held got=%h/%b exp=0000/0", bcd, running);
    end
    start = 1'b0;
    tick  = 1'b0;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_count_basic();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0010 || bcd !== to_bcd(m_secs)) begin
      n_fail++; $display("FAIL basic_10_ticks got=%h exp=0010", bcd);
    end
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL basic_running got=%b exp=1", running); end
  endtask

  task automatic test_stop();
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 59; i++) cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0059) begin n_fail++; $display("FAIL stop_59 got=%h exp=0059", bcd); end
    cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0100) begin n_fail++; $display("FAIL stop_carry_min got=%h exp=0100", bcd); end
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0100) begin n_fail++; $display("FAIL stop_hold got=%h exp=0100", bcd); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL stop_running got=%b exp=0", running); end
  endtask

  task automatic test_rollover();
    bit wrap_early;
    wrap_early = 1'b0;
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < LIMIT - 1; i++) begin
      cycle(0, 0, 0, 1, 0);
      if (wrap !== 1'b0) wrap_early = 1'b1;
    end
    n_checks++;
    if (wrap_early) begin n_fail++; $display("FAIL roll_wrap_early got=1 exp=0"); end
    n_checks++;
    if (bcd !== 16'h5959 || bcd !== to_bcd(m_secs)) begin
      n_fail++; $display("FAIL roll_preload got=%h exp=5959", bcd);
    end
    cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0000 || wrap !== 1'b1 || wrap !== m_wrap) begin
      n_fail++; $display("FAIL roll_wrap got=%h/%b exp=0000/1", bcd, wrap);
    end
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL roll_running got=%b exp=1", running); end
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (wrap !== 1'b0) begin n_fail++; $display("FAIL roll_wrap_pulse got=%b exp=0", wrap); end
    cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0001 || running !== 1'b1) begin
      n_fail++; $display("FAIL roll_continue got=%h/%b exp=0001/1", bcd, running);
    end
  endtask

  task automatic test_simultaneous();
    cycle(0, 0, 1, 0, 0);
    // tick together with start in IDLE must not be counted
    cycle(1, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0000 || running !== 1'b1) begin
      n_fail++; $display("FAIL tick_start got=%h/%b exp=0000/1", bcd, running);
    end
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0008 || running !== 1'b0) begin
      n_fail++; $display("FAIL tick_stop got=%h/%b exp=0008/0", bcd, running);
    end
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0012) begin n_fail++; $display("FAIL pre_clear got=%h exp=0012", bcd); end
    cycle(0, 0, 1, 1, 0);
    n_checks++;
    if (bcd !== 16'h0000 || running !== 1'b0) begin
      n_fail++; $display("FAIL tick_clear got=%h/%b exp=0000/0", bcd, running);
    end
    // back in IDLE: ticks ignored
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0000) begin n_fail++; $display("FAIL idle_no_count got=%h exp=0000", bcd); end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 225; i++) cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0345) begin n_fail++; $display("FAIL areset_pre got=%h exp=0345", bcd); end
    // keep tick high; assert reset between edges
    tick = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bcd !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL areset_immediate got=%h/%b/%b exp=0000/0/0", bcd, running, wrap);
    end
    model_reset();
    tick = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

`ifdef SW_LAP_EN
  task automatic test_lap();
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    n_checks++;
    if (lap_valid !== 1'b0) begin n_fail++; $display("FAIL lap_idle got=%b exp=0", lap_valid); end
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1);
    n_checks++;
    if (lap_bcd !== 16'h0030 || lap_valid !== 1'b1) begin
      n_fail++; $display("FAIL lap_capture got=%h/%b exp=0030/1", lap_bcd, lap_valid);
    end
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (bcd !== 16'h0035 || lap_bcd !== 16'h0030) begin
      n_fail++; $display("FAIL lap_hold got=%h/%h exp=0035/0030", bcd, lap_bcd);
    end
    cycle(0, 0, 1, 0, 0);
    n_checks++;
    if (lap_bcd !== 16'h0000 || lap_valid !== 1'b0 || bcd !== 16'h0000) begin
      n_fail++; $display("FAIL lap_clear got=%h/%b/%h exp=0000/0/0000", lap_bcd, lap_valid, bcd);
    end
  endtask
`endif

  task automatic test_random();
    int errs;
    bit st, sp, cl, tk, lp;
    errs = 0;
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      cl = ($urandom_range(31) == 0);
      sp = ($urandom_range(9) == 0);
      st = !sp && ($urandom_range(7) == 0);
      tk = $urandom_range(1) == 1;
      lp = ($urandom_range(7) == 0);
      cycle(st, sp, cl, tk, lp);
      n_checks++;
      if (bcd !== to_bcd(m_secs) || running !== (m_state == S_RUN) || wrap !== m_wrap) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d got=%h/%b/%b exp=%h/%b/%b", i, bcd, running, wrap,
                   to_bcd(m_secs), (m_state == S_RUN), m_wrap);
      end
`ifdef SW_LAP_EN
      n_checks++;
      if (lap_bcd !== to_bcd(m_lap_secs) || lap_valid !== m_lap_vld) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_lap%0d got=%h/%b exp=%h/%b", i, lap_bcd, lap_valid,
                   to_bcd(m_lap_secs), m_lap_vld);
      end
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    tick     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    clear    = 1'b0;
`ifdef SW_LAP_EN
    lap      = 1'b0;
`endif
    model_reset();
    #7;
    test_reset();
    @(posedge clk);
    #1;
    test_count_basic();
    test_stop();
    test_rollover();
    test_simultaneous();
    test_async_reset();
`ifdef SW_LAP_EN
    test_lap();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
